xnor_cmp_arb: RTL and testbench

XNOR_CMP_ARB -- requirements
Module: xnor_cmp_arb

---
 rtl/xnor_cmp_pkg.sv | 20 ++
 rtl/xnor2.sv | 8 +
 rtl/xnor_rr_arb.sv | 34 +++
 rtl/xnor_cmp_arb.sv | 130 +++++++++++++
 tb/tb_xnor_cmp_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xnor_cmp_pkg.sv
// Shared types and sizing helpers for the serial XNOR compare arbiter.
package xnor_cmp_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Index width that stays at least one bit even for tiny counts.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDW_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/xnor2.sv
// Two-input XNOR cell used as the single-bit compare element.
module xnor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

// File: rtl/xnor_rr_arb.sv
// Round-robin arbiter: first valid index searching cyclically after last_grant.
module xnor_rr_arb
    import xnor_cmp_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = last_grant;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
            if (!grant_any && valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign grant[gi] = grant_any && (grant_idx == IDW'(gi));
    end

endmodule

// File: rtl/xnor_cmp_arb.sv
// Shared bit-serial equality comparator: arbitrates NREQ requesters, compares
// the granted operands one bit per cycle through an XNOR cell, then holds the result.
module xnor_cmp_arb
    import xnor_cmp_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = id_width(NREQ),
    parameter int CW   = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_match,
    output logic            busy
);

    state_t         state_reg, state_next;
    logic [IDW-1:0] last_grant_reg, last_grant_next;
    logic [IDW-1:0] id_reg, id_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           match_reg, match_next;
    logic [W-1:0]   a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            xnor_out;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*W +: W];
        assign b_arr[gi] = req_b[gi*W +: W];
    end

    xnor_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Operands shift right each cycle, so bit 0 always carries the bit under test.
    xnor2 u_xnor (
        .a (a_reg[0]),
        .b (b_reg[0]),
        .y (xnor_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDW'(NREQ - 1);
            id_reg         <= '0;
            cnt_reg        <= '0;
            match_reg      <= 1'b1;
            a_reg          <= '0;
            b_reg          <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            id_reg         <= id_next;
            cnt_reg        <= cnt_next;
            match_reg      <= match_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        id_next         = id_reg;
        cnt_next        = cnt_reg;
        match_next      = match_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        req_ready       = '0;
        rsp_valid       = 1'b0;
        rsp_id          = '0;
        rsp_match       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    req_ready       = grant & {NREQ{rst_n}};
                    last_grant_next = grant_idx;
                    id_next         = grant_idx;
                    a_next          = a_arr[grant_idx];
                    b_next          = b_arr[grant_idx];
                    cnt_next        = '0;
                    match_next      = 1'b1;
                    state_next      = SHIFT;
                end
            end
            SHIFT: begin
                match_next = match_reg & xnor_out;
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                // Always the full W cycles, no early exit, so latency is fixed.
                if (cnt_reg == CW'(W - 1)) begin
                    cnt_next   = '0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_reg;
                rsp_match = match_reg;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_xnor_cmp_arb.sv
// Scenario bench for xnor_cmp_arb with an expected-result queue.
module tb_xnor_cmp_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_match;
    logic              busy;

    xnor_cmp_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_match (rsp_match),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [IDW-1:0] id; logic m; } exp_t;
    typedef struct { int c; logic [NREQ-1:0] g; } acc_t;
    typedef struct { int c; logic [IDW-1:0] id; logic m; } rsp_t;

    exp_t exp_q[$];
    acc_t acc_log[$];
    rsp_t rsp_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference round-robin pick: first valid index after last, cyclically.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Runs from a drive point until n_rsp handshakes are logged; returns at the sample point.
    task automatic pump(input int n_rsp, input int budget, input bit drop, output bit ok);
        logic [NREQ-1:0] clr;
        int got;
        ok  = 1'b0;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            #3;
            clr = req_ready;
            if (req_ready != '0) acc_log.push_back(acc_t'{cyc, req_ready});
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back(rsp_t'{cyc, rsp_id, rsp_match});
                got++;
            end
            if (got == n_rsp) begin
                ok = 1'b1;
                break;
            end
            to_drive();
            if (drop) req_valid = req_valid & ~clr;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        to_drive();
        to_drive();
        #3;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        n_cmp++; if (rsp_id !== '0) begin n_bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        n_cmp++; if (rsp_match !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_match got=%b want=0", rsp_match); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        to_drive();
        rst_n     = 1'b1;
        req_valid = '0;
        $display("reset: checked outputs held low");
    endtask

    task automatic test_match();
        bit   ok;
        exp_t e;
        set_op(0, 8'hA5, 8'hA5);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        exp_q.push_back(exp_t'{2'd0, 1'b1});
        acc_log.delete();
        rsp_log.delete();
        pump(1, 40, 1'b1, ok);
        n_cmp++;
        if (!ok || acc_log.size() != 1 || rsp_log.size() != 1) begin
            n_bad++;
            $display("FAIL match_done ok=%0b acc=%0d rsp=%0d want 1/1/1", ok, acc_log.size(), rsp_log.size());
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (acc_log[0].g !== 4'b0001) begin n_bad++; $display("FAIL match_grant got=%b want=0001", acc_log[0].g); end
            n_cmp++; if (rsp_log[0].c - acc_log[0].c != W + 1) begin n_bad++; $display("FAIL match_latency got=%0d want=%0d", rsp_log[0].c - acc_log[0].c, W + 1); end
            n_cmp++; if (rsp_log[0].id !== e.id) begin n_bad++; $display("FAIL match_id got=%0d want=%0d", rsp_log[0].id, e.id); end
            n_cmp++; if (rsp_log[0].m !== e.m) begin n_bad++; $display("FAIL match_result got=%b want=%b", rsp_log[0].m, e.m); end
            $display("match: id=%0d match=%b latency=%0d", rsp_log[0].id, rsp_log[0].m, rsp_log[0].c - acc_log[0].c);
        end
        to_drive();
        #3;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL match_idle busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
        to_drive();
    endtask

    task automatic test_last_bit_mismatch();
        bit   ok;
        exp_t e;
        set_op(2, 8'h80, 8'h00);
        req_valid = 4'b0100;
        exp_q.push_back(exp_t'{2'd2, 1'b0});
        acc_log.delete();
        rsp_log.delete();
        pump(1, 40, 1'b1, ok);
        n_cmp++;
        if (!ok || acc_log.size() != 1 || rsp_log.size() != 1) begin
            n_bad++;
            $display("FAIL msb_done ok=%0b acc=%0d rsp=%0d want 1/1/1", ok, acc_log.size(), rsp_log.size());
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (acc_log[0].g !== 4'b0100) begin n_bad++; $display("FAIL msb_grant got=%b want=0100", acc_log[0].g); end
            n_cmp++; if (rsp_log[0].id !== e.id) begin n_bad++; $display("FAIL msb_id got=%0d want=%0d", rsp_log[0].id, e.id); end
            n_cmp++; if (rsp_log[0].m !== e.m) begin n_bad++; $display("FAIL msb_result got=%b want=%b", rsp_log[0].m, e.m); end
            $display("last-bit mismatch: id=%0d match=%b", rsp_log[0].id, rsp_log[0].m);
        end
        to_drive();
    endtask

    task automatic test_rr_skip();
        bit   ok;
        exp_t e;
        int   g0, g1;
        // Single request from 1 leaves last_grant at 1.
        set_op(1, 8'h3C, 8'h3C);
        set_op(3, 8'h01, 8'h00);
        req_valid = 4'b0010;
        exp_q.push_back(exp_t'{2'd1, 1'b1});
        g0 = rr_pick(4'b1010, 1);
        g1 = rr_pick(4'b1010 & ~(4'b0001 << g0), g0);
        exp_q.push_back(exp_t'{IDW'(g0), (g0 == 1)});
        exp_q.push_back(exp_t'{IDW'(g1), (g1 == 1)});
        acc_log.delete();
        rsp_log.delete();
        pump(1, 40, 1'b1, ok);
        to_drive();
        req_valid = 4'b1010;
        pump(2, 80, 1'b1, ok);
        n_cmp++;
        if (!ok || acc_log.size() != 3 || rsp_log.size() != 3) begin
            n_bad++;
            $display("FAIL rr_skip_done ok=%0b acc=%0d rsp=%0d want 1/3/3", ok, acc_log.size(), rsp_log.size());
        end else begin
            n_cmp++; if (acc_log[1].g !== NREQ'(1 << g0)) begin n_bad++; $display("FAIL rr_skip_grant1 got=%b want=%0d", acc_log[1].g, g0); end
            n_cmp++; if (acc_log[2].g !== NREQ'(1 << g1)) begin n_bad++; $display("FAIL rr_skip_grant2 got=%b want=%0d", acc_log[2].g, g1); end
            for (int k = 0; k < 3; k++) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rsp_log[k].id !== e.id || rsp_log[k].m !== e.m) begin
                    n_bad++;
                    $display("FAIL rr_skip_rsp%0d got id=%0d m=%b want id=%0d m=%b", k, rsp_log[k].id, rsp_log[k].m, e.id, e.m);
                end
                $display("rr skip: rsp %0d id=%0d match=%b", k, rsp_log[k].id, rsp_log[k].m);
            end
        end
        exp_q.delete();
        to_drive();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   seen;
        set_op(0, 8'hFF, 8'hFE);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        exp_q.push_back(exp_t'{IDW'(rr_pick(4'b0001, 1)), 1'b0});
        #3;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_accept got=%b want=0001", req_ready); end
        to_drive();
        req_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #3;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            to_drive();
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL bp_timeout rsp_valid=%b want=1", rsp_valid);
        end else begin
            e = exp_q.pop_front();
            req_valid = '1;
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_match !== e.m || req_ready !== '0) begin
                    n_bad++;
                    $display("FAIL bp_hold%0d got v=%b id=%0d m=%b rdy=%b want 1/%0d/%b/0", k, rsp_valid, rsp_id, rsp_match, req_ready, e.id, e.m);
                end
                $display("backpressure: cycle %0d id=%0d match=%b", k, rsp_id, rsp_match);
                to_drive();
                #3;
            end
            to_drive();
            rsp_ready = 1'b1;
            req_valid = '0;
            #3;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_handshake got=%b want=1", rsp_valid); end
            to_drive();
            #3;
            n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
        end
        to_drive();
    endtask

    task automatic test_round_robin();
        bit   ok;
        exp_t e;
        int   gexp[6];
        int   last;
        rst_n     = 1'b0;
        req_valid = '0;
        to_drive();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, W'(i * 37 + 3), W'(i * 37 + 3) ^ ((i % 2 == 1) ? 8'h80 : 8'h00));
        end
        last = NREQ - 1;
        for (int k = 0; k < 6; k++) begin
            gexp[k] = rr_pick('1, last);
            exp_q.push_back(exp_t'{IDW'(gexp[k]), (gexp[k] % 2 == 0)});
            last = gexp[k];
        end
        acc_log.delete();
        rsp_log.delete();
        req_valid = '1;
        rsp_ready = 1'b1;
        pump(6, 6 * (W + 2) + 20, 1'b0, ok);
        req_valid = '0;
        n_cmp++;
        if (!ok || acc_log.size() != 6 || rsp_log.size() != 6) begin
            n_bad++;
            $display("FAIL rr_done ok=%0b acc=%0d rsp=%0d want 1/6/6", ok, acc_log.size(), rsp_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                e = exp_q.pop_front();
                n_cmp++; if (acc_log[k].g !== NREQ'(1 << gexp[k])) begin n_bad++; $display("FAIL rr_grant%0d got=%b want=%0d", k, acc_log[k].g, gexp[k]); end
                if (k > 0) begin
                    n_cmp++; if (acc_log[k].c - acc_log[k-1].c != W + 2) begin n_bad++; $display("FAIL rr_gap%0d got=%0d want=%0d", k, acc_log[k].c - acc_log[k-1].c, W + 2); end
                end
                n_cmp++;
                if (rsp_log[k].id !== e.id || rsp_log[k].m !== e.m) begin
                    n_bad++;
                    $display("FAIL rr_rsp%0d got id=%0d m=%b want id=%0d m=%b", k, rsp_log[k].id, rsp_log[k].m, e.id, e.m);
                end
                $display("round robin: accept %0d grant=%b id=%0d match=%b", k, acc_log[k].g, rsp_log[k].id, rsp_log[k].m);
            end
        end
        exp_q.delete();
        to_drive();
    endtask

    task automatic test_reset_mid_shift();
        bit   ok;
        bit   saw;
        exp_t e;
        set_op(2, 8'h55, 8'h55);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #3;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL rst_mid_accept got=%b want=0100", req_ready); end
        to_drive();
        req_valid = '0;
        to_drive();
        to_drive();
        to_drive();
        rst_n = 1'b0;
        to_drive();
        rst_n = 1'b1;
        #3;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_match !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs got v=%b id=%0d m=%b busy=%b rdy=%b want all 0", rsp_valid, rsp_id, rsp_match, busy, req_ready);
        end
        saw = 1'b0;
        for (int k = 0; k < W + 6; k++) begin
            to_drive();
            #3;
            if (rsp_valid) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_rsp got=%b want=0", saw); end
        to_drive();
        set_op(0, 8'h0F, 8'h0F);
        req_valid = '1;
        exp_q.push_back(exp_t'{IDW'(rr_pick('1, NREQ - 1)), 1'b1});
        #3;
        n_cmp++; if (req_ready !== NREQ'(1 << rr_pick('1, NREQ - 1))) begin n_bad++; $display("FAIL rst_mid_first_grant got=%b want=0001", req_ready); end
        to_drive();
        req_valid = '0;
        acc_log.delete();
        rsp_log.delete();
        pump(1, 40, 1'b1, ok);
        n_cmp++;
        if (!ok || rsp_log.size() != 1) begin
            n_bad++;
            $display("FAIL rst_mid_drain ok=%0b rsp=%0d want 1/1", ok, rsp_log.size());
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rsp_log[0].id !== e.id || rsp_log[0].m !== e.m) begin
                n_bad++;
                $display("FAIL rst_mid_rsp got id=%0d m=%b want id=%0d m=%b", rsp_log[0].id, rsp_log[0].m, e.id, e.m);
            end
            $display("reset mid-shift: follow-up id=%0d match=%b", rsp_log[0].id, rsp_log[0].m);
        end
        to_drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match();
        test_last_bit_mismatch();
        test_rr_skip();
        test_backpressure();
        test_round_robin();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
